// File: rtl/gpi_debounce_if.sv
// Raw input / debounced output bundle between the external pins and the GPI core.
// master = pin side / consumer, slave = debounce block.
interface gpi_debounce_if #(
    parameter int W = 8
);
    logic [W-1:0] raw_in;
    logic [W-1:0] db_out;
    logic [W-1:0] rise_tick;
    logic [W-1:0] fall_tick;

    modport master (
        output raw_in,
        input  db_out,
        input  rise_tick,
        input  fall_tick
    );

    modport slave (
        input  raw_in,
        output db_out,
        output rise_tick,
        output fall_tick
    );
endinterface

// File: rtl/gpi_debounce.sv
// Synchronise and debounce W raw inputs; optional rise/fall ticks (GPI_DEBOUNCE_EDGE_EN).
// Latency: SYNC_STAGES edges of synchroniser, then DB_TICKS cycles of stable hold in WAIT.
// No backpressure: free-running input conditioner, outputs are levels and one-cycle pulses.
module gpi_debounce #(
    parameter int W           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DB_TICKS    = 1_000_000
) (
    input  logic          clk,
    input  logic          reset_n,
    gpi_debounce_if.slave io
);

    localparam int             CW      = $clog2(DB_TICKS + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DB_TICKS);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        STABLE0 = 2'd0,
        WAIT1   = 2'd1,
        STABLE1 = 2'd2,
        WAIT0   = 2'd3
    } db_state_t;

    logic [W-1:0]  sync_q [SYNC_STAGES];
    logic [W-1:0]  s;

    db_state_t     state_q [W];
    db_state_t     state_d [W];
    logic [CW-1:0] cnt_q   [W];
    logic [CW-1:0] cnt_d   [W];
    logic [W-1:0]  db_q;
    logic [W-1:0]  db_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= io.raw_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < W; i++) begin
                state_q[i] <= STABLE0;
                cnt_q[i]   <= '0;
            end
            db_q <= '0;
        end else begin
            for (int i = 0; i < W; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            db_q <= db_d;
        end
    end

`ifdef GPI_DEBOUNCE_EDGE_EN
    logic [W-1:0] rise_d;
    logic [W-1:0] fall_d;
    logic [W-1:0] rise_q;
    logic [W-1:0] fall_q;
`endif

    // The counter is cleared whenever a WAIT state resolves, so it can never pass CNT_MAX.
    always_comb begin
`ifdef GPI_DEBOUNCE_EDGE_EN
        rise_d = '0;
        fall_d = '0;
`endif
        db_d = '0;
        for (int i = 0; i < W; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                STABLE0: begin
                    if (s[i]) begin
                        state_d[i] = WAIT1;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
                        cnt_d[i]   = '0;
                    end
                end
                WAIT1: begin
                    if (!s[i]) begin
                        state_d[i] = STABLE0;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = STABLE1;
                        cnt_d[i]   = '0;
`ifdef GPI_DEBOUNCE_EDGE_EN
                        rise_d[i]  = 1'b1;
`endif
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CNT_ONE;
                    end
                end
                STABLE1: begin
                    if (!s[i]) begin
                        state_d[i] = WAIT0;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
                        cnt_d[i]   = '0;
                    end
                end
                WAIT0: begin
                    if (s[i]) begin
                        state_d[i] = STABLE1;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = STABLE0;
                        cnt_d[i]   = '0;
`ifdef GPI_DEBOUNCE_EDGE_EN
                        fall_d[i]  = 1'b1;
`endif
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = STABLE0;
                    cnt_d[i]   = '0;
                end
            endcase
            // db follows the next state so level and ticks update on the same edge.
            db_d[i] = (state_d[i] == STABLE1) || (state_d[i] == WAIT0);
        end
    end

    assign io.db_out = db_q;

`ifdef GPI_DEBOUNCE_EDGE_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign io.rise_tick = rise_q;
    assign io.fall_tick = fall_q;
`else
    assign io.rise_tick = '0;
    assign io.fall_tick = '0;
`endif

endmodule

// File: tb/tb_gpi_debounce.sv
// Directed bench for gpi_debounce with W=8, SYNC_STAGES=2, DB_TICKS=4.
// Tick expectations collapse to zero when the edge option is not compiled in.
module tb_gpi_debounce;

`ifdef GPI_DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic clk;
    logic reset_n;

    int checks   = 0;
    int failures = 0;
    int rise_cnt [8];
    int fall_cnt [8];
    logic both_seen;
    logic [7:0] db_or;

    gpi_debounce_if #(.W(8)) dut_if ();

    gpi_debounce #(
        .W           (8),
        .SYNC_STAGES (2),
        .DB_TICKS    (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io      (dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] te(input logic [7:0] v);
        return EDGE_EN ? v : 8'h00;
    endfunction

    task automatic clear_counts();
        for (int i = 0; i < 8; i++) begin
            rise_cnt[i] = 0;
            fall_cnt[i] = 0;
        end
        db_or = 8'h00;
    endtask

    // One clock: advance past the rising edge and sample on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (dut_if.rise_tick[i]) rise_cnt[i]++;
            if (dut_if.fall_tick[i]) fall_cnt[i]++;
        end
        if ((dut_if.rise_tick & dut_if.fall_tick) != 8'h00) both_seen = 1'b1;
        db_or = db_or | dut_if.db_out;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        both_seen     = 1'b0;
        clear_counts();
        reset_n       = 1'b0;
        dut_if.raw_in = 8'hFF;

        // 1: reset holds everything low despite all-ones input
        steps(3);
        check("rst_db",   dut_if.db_out,    8'h00);
        check("rst_rise", dut_if.rise_tick, 8'h00);
        check("rst_fall", dut_if.fall_tick, 8'h00);
        dut_if.raw_in = 8'h00;
        reset_n       = 1'b1;
        steps(3);
        check("idle_db", dut_if.db_out, 8'h00);

        // 2: clean rise on bit 0, accepted on the 7th edge after the change
        dut_if.raw_in = 8'h01;
        steps(6);
        check("rise_early_db",   dut_if.db_out,    8'h00);
        check("rise_early_tick", dut_if.rise_tick, 8'h00);
        step();
        check("rise_db",   dut_if.db_out,    8'h01);
        check("rise_tick", dut_if.rise_tick, te(8'h01));
        check("rise_fall", dut_if.fall_tick, 8'h00);
        step();
        check("rise_tick_end", dut_if.rise_tick, 8'h00);
        check("rise_db_hold",  dut_if.db_out,    8'h01);

        // 3: 3-cycle glitch on bit 3 is rejected
        clear_counts();
        dut_if.raw_in = 8'h09;
        steps(3);
        dut_if.raw_in = 8'h01;
        steps(12);
        check("glitch_db_seen", {24'h0, db_or & 8'h08}, 32'h0);
        check("glitch_rise",    rise_cnt[3],           0);
        check("glitch_db",      dut_if.db_out,         8'h01);

        // 4: bounce on bit 2, final hold starts with the 5th value
        clear_counts();
        dut_if.raw_in = 8'h05; step();
        dut_if.raw_in = 8'h01; step();
        dut_if.raw_in = 8'h05; step();
        dut_if.raw_in = 8'h01; step();
        dut_if.raw_in = 8'h05; step();
        steps(5);
        check("bounce_early", {24'h0, dut_if.db_out & 8'h04}, 32'h0);
        step();
        check("bounce_db",   dut_if.db_out,    8'h05);
        check("bounce_tick", dut_if.rise_tick, te(8'h04));
        steps(4);
        check("bounce_rise_cnt", rise_cnt[2], EDGE_EN ? 1 : 0);

        // back to all zero, bits 0 and 2 fall together
        clear_counts();
        dut_if.raw_in = 8'h00;
        steps(6);
        check("fall05_early", dut_if.db_out, 8'h05);
        step();
        check("fall05_db",   dut_if.db_out,    8'h00);
        check("fall05_tick", dut_if.fall_tick, te(8'h05));

        // 5: parallel rise and fall of A5
        clear_counts();
        dut_if.raw_in = 8'hA5;
        steps(6);
        check("par_early", dut_if.db_out, 8'h00);
        step();
        check("par_db",   dut_if.db_out,    8'hA5);
        check("par_rise", dut_if.rise_tick, te(8'hA5));
        step();
        check("par_rise_end", dut_if.rise_tick, 8'h00);
        dut_if.raw_in = 8'h00;
        steps(6);
        check("par_fall_early", dut_if.db_out, 8'hA5);
        step();
        check("par_fall_db",   dut_if.db_out,    8'h00);
        check("par_fall_tick", dut_if.fall_tick, te(8'hA5));
        check("par_fall_rise", dut_if.rise_tick, 8'h00);
        step();
        check("par_fall_end", dut_if.fall_tick, 8'h00);

        // 6: reset two cycles into WAIT1 discards the partial count
        dut_if.raw_in = 8'h01;
        steps(4);
        reset_n = 1'b0;
        #1;
        check("midrst_db", dut_if.db_out, 8'h00);
        steps(2);
        reset_n = 1'b1;
        steps(6);
        check("midrst_early", dut_if.db_out, 8'h00);
        step();
        check("midrst_db_after", dut_if.db_out,    8'h01);
        check("midrst_tick",     dut_if.rise_tick, te(8'h01));

        // asynchronous clear of a high output without any clock edge
        step();
        reset_n = 1'b0;
        #1;
        check("async_rst_db", dut_if.db_out, 8'h00);
        reset_n = 1'b1;

        check("never_both", {31'h0, both_seen}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
